// File: rtl/ctrlpipe_pkg.sv
// ctrlpipe shared package: per-boundary control widths,
// bubble words and EX bundle field offsets.
package ctrlpipe_pkg;

  localparam int EXCTRL_W  = 8;
  localparam int MEMCTRL_W = 4;
  localparam int WBCTRL_W  = 2;

  localparam logic [EXCTRL_W-1:0]  EX_BUBBLE  = '0;
  localparam logic [MEMCTRL_W-1:0] MEM_BUBBLE = '0;
  localparam logic [WBCTRL_W-1:0]  WB_BUBBLE  = '0;

  localparam int EX_ALUOP_LSB     = 0;
  localparam int EX_ALUOP_W       = 3;
  localparam int EX_REGDST_LSB    = 3;
  localparam int EX_REGDST_W      = 2;
  localparam int EX_ALUSRC_LSB    = 5;
  localparam int EX_ALUSRC_W      = 2;
  localparam int EX_ALUALTSRC_LSB = 7;

  function automatic logic [EXCTRL_W-1:0] ex_pack(
    input logic       alualtsrc,
    input logic [1:0] alusrc,
    input logic [1:0] regdst,
    input logic [2:0] aluop
  );
    return {alualtsrc, alusrc, regdst, aluop};
  endfunction

endpackage

// File: rtl/ctrlpipe_if.sv
// ctrlpipe bus: stall/flush broadcast, control word in/out.
// Counter signals exist only when CTRLPIPE_STATS_EN is defined.
interface ctrlpipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
);
  import ctrlpipe_pkg::*;

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             stall;
  logic             flush;
  logic             validin;
  logic [WIDTH-1:0] ctrlin;
  logic             validout;
  logic [WIDTH-1:0] ctrlout;
  logic [OCC_W-1:0] occupancy;
`ifdef CTRLPIPE_STATS_EN
  logic [15:0]      stallcnt;
  logic [15:0]      flushcnt;
`endif

  modport master (
    output stall, flush, validin, ctrlin,
`ifdef CTRLPIPE_STATS_EN
    input  stallcnt, flushcnt,
`endif
    input  validout, ctrlout, occupancy
  );

  modport slave (
    input  stall, flush, validin, ctrlin,
`ifdef CTRLPIPE_STATS_EN
    output stallcnt, flushcnt,
`endif
    output validout, ctrlout, occupancy
  );

endinterface

// File: rtl/ctrlpipe_stage.sv
// ctrlpipe_stage: one valid/control flop pair.
// Invalid slots always hold the bubble word.
module ctrlpipe_stage #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);
  import ctrlpipe_pkg::*;

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  // next state: rst > flush > stall > load
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    priority case (1'b1)
      rst: begin
        v_d = 1'b0;
        d_d = BUBBLE;
      end
      flush_i: begin
        v_d = 1'b0;
        d_d = BUBBLE;
      end
      stall_i: begin
        v_d = v_q;
        d_d = d_q;
      end
      default: begin
        v_d = v_i;
        d_d = v_i ? d_i : BUBBLE;
      end
    endcase
  end

  // slot register
  always_ff @(posedge clk) begin
    v_q <= v_d;
    d_q <= d_d;
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/ctrlpipe.sv
// ctrlpipe: DEPTH-stage control bundle pipeline with stall/flush.
// Optional counters under CTRLPIPE_STATS_EN.
module ctrlpipe #(
  parameter int               WIDTH  = 8,
  parameter int               DEPTH  = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input logic      clk,
  input logic      rst,
  ctrlpipe_if.slave bus
);
  import ctrlpipe_pkg::*;

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic             vin;
    logic [WIDTH-1:0] din;
    if (i == 0) begin : g_head
      assign vin = bus.validin;
      assign din = bus.ctrlin;
    end else begin : g_body
      assign vin = v_q[i-1];
      assign din = d_q[i-1];
    end
    ctrlpipe_stage #(
      .WIDTH  (WIDTH),
      .BUBBLE (BUBBLE)
    ) u_stg (
      .clk     (clk),
      .rst     (rst),
      .stall_i (bus.stall),
      .flush_i (bus.flush),
      .v_i     (vin),
      .d_i     (din),
      .v_o     (v_q[i]),
      .d_o     (d_q[i])
    );
  end

  // occupancy tracks the slot valids on the same edge
  always_comb begin
    occ_d = occ_q;
    priority case (1'b1)
      rst:       occ_d = '0;
      bus.flush: occ_d = '0;
      bus.stall: occ_d = occ_q;
      default:   occ_d = occ_q
                       + OCC_W'(bus.validin)
                       - OCC_W'(v_q[DEPTH-1]);
    endcase
  end

  // occupancy register
  always_ff @(posedge clk) begin
    occ_q <= occ_d;
  end

  assign bus.validout  = v_q[DEPTH-1];
  assign bus.ctrlout   = d_q[DEPTH-1];
  assign bus.occupancy = occ_q;

`ifdef CTRLPIPE_STATS_EN
  logic [15:0] stc_q, stc_d;
  logic [15:0] flc_q, flc_d;

  // saturating stall / effective-flush counters
  always_comb begin
    stc_d = stc_q;
    flc_d = flc_q;
    if (rst) begin
      stc_d = '0;
      flc_d = '0;
    end else begin
      if (bus.stall && !bus.flush && stc_q != 16'hFFFF)
        stc_d = stc_q + 16'd1;
      if (bus.flush && (|v_q) && flc_q != 16'hFFFF)
        flc_d = flc_q + 16'd1;
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    stc_q <= stc_d;
    flc_q <= flc_d;
  end

  assign bus.stallcnt = stc_q;
  assign bus.flushcnt = flc_q;
`endif

endmodule

// File: tb/tb_ctrlpipe.sv
// tb_ctrlpipe: directed vector table plus hand sequences
// for DEPTH=3, WIDTH=8, BUBBLE=0.
module tb_ctrlpipe;
  import ctrlpipe_pkg::*;

  localparam int W = 8;
  localparam int D = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ctrlpipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

  ctrlpipe #(
    .WIDTH  (W),
    .DEPTH  (D),
    .BUBBLE (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       stall;
    logic       flush;
    logic       vin;
    logic [7:0] din;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] eo;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s,
                       input logic f, input logic v,
                       input logic [7:0] d);
    rst         = r;
    bus.stall   = s;
    bus.flush   = f;
    bus.validin = v;
    bus.ctrlin  = d;
  endtask

  task automatic add(input logic r, input logic s,
                     input logic f, input logic v,
                     input logic [7:0] d, input logic ev,
                     input logic [7:0] ed,
                     input logic [1:0] eo);
    vec_t t;
    t = '{r, s, f, v, d, ev, ed, eo};
    vq.push_back(t);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    //  rst s f v din    ev ed     occ
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 1, 8'hA1, 0, 8'h00, 1);
    add(0, 0, 0, 1, 8'hB2, 0, 8'h00, 2);
    add(0, 0, 0, 1, 8'hC3, 1, 8'hA1, 3);
    add(0, 0, 0, 0, 8'h7E, 1, 8'hB2, 2);
    add(0, 0, 0, 1, 8'h5A, 1, 8'hC3, 2);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 1);
    add(0, 1, 0, 1, 8'hEE, 0, 8'h00, 1);
    add(0, 1, 0, 1, 8'hEE, 0, 8'h00, 1);
    add(0, 1, 0, 1, 8'hEE, 0, 8'h00, 1);
    add(0, 1, 0, 1, 8'hEE, 0, 8'h00, 1);
    add(0, 0, 0, 0, 8'h00, 1, 8'h5A, 1);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 1, 8'h11, 0, 8'h00, 1);
    add(0, 0, 0, 1, 8'h22, 0, 8'h00, 2);
    add(0, 0, 0, 1, 8'h33, 1, 8'h11, 3);
    add(0, 1, 1, 1, 8'hFF, 0, 8'h00, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    add(0, 0, 0, 1, 8'h44, 0, 8'h00, 1);
    add(0, 0, 0, 1, 8'h55, 0, 8'h00, 2);
    add(1, 0, 0, 1, 8'h66, 0, 8'h00, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].stall, vq[i].flush,
            vq[i].vin, vq[i].din);
      tick();
      chk($sformatf("v%0d.validout", i),
          int'(bus.validout), int'(vq[i].ev));
      chk($sformatf("v%0d.ctrlout", i),
          int'(bus.ctrlout), int'(vq[i].ed));
      chk($sformatf("v%0d.occupancy", i),
          int'(bus.occupancy), int'(vq[i].eo));
`ifdef CTRLPIPE_STATS_EN
      if (i == 20) begin
        chk("stallcnt_mid", int'(bus.stallcnt), 4);
        chk("flushcnt_mid", int'(bus.flushcnt), 1);
      end
`endif
    end

    // fill fully, then a stall that must not shift anything
    drive(0, 0, 0, 1, 8'h01); tick();
    drive(0, 0, 0, 1, 8'h02); tick();
    drive(0, 0, 0, 1, 8'h03); tick();
    drive(0, 0, 0, 1, 8'h04); tick();
    chk("full_ctrlout", int'(bus.ctrlout), 8'h02);
    chk("full_occ", int'(bus.occupancy), 3);
    drive(0, 1, 0, 1, 8'h09); tick();
    chk("stall_full_ctrlout", int'(bus.ctrlout), 8'h02);
    chk("stall_full_occ", int'(bus.occupancy), 3);
    drive(0, 0, 0, 0, 8'h00); tick();
    chk("drain1_ctrlout", int'(bus.ctrlout), 8'h03);
    tick();
    chk("drain2_ctrlout", int'(bus.ctrlout), 8'h04);
    tick();
    chk("drain3_valid", int'(bus.validout), 0);
    chk("drain3_occ", int'(bus.occupancy), 0);

`ifdef CTRLPIPE_STATS_EN
    drive(1, 0, 0, 0, 8'h00); tick();
    chk("stats_rst_stall", int'(bus.stallcnt), 0);
    chk("stats_rst_flush", int'(bus.flushcnt), 0);
    drive(0, 0, 1, 0, 8'h00); tick();
    chk("flush_empty", int'(bus.flushcnt), 0);
    drive(0, 0, 0, 1, 8'h10); tick();
    drive(0, 0, 1, 0, 8'h00); tick();
    chk("flush_valid", int'(bus.flushcnt), 1);
    drive(0, 1, 0, 0, 8'h00);
    for (int k = 0; k < 70000; k++) tick();
    chk("stall_sat", int'(bus.stallcnt), 16'hFFFF);
    tick();
    tick();
    chk("stall_sat_hold", int'(bus.stallcnt), 16'hFFFF);
    drive(1, 1, 0, 0, 8'h00); tick();
    chk("sat_rst_stall", int'(bus.stallcnt), 0);
    chk("sat_rst_flush", int'(bus.flushcnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
